// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
// Contents: access size encodings, FSM state type, misalignment check.
package mem_pkg;

   // Access size encodings carried on Size_i. 2'b11 is reserved and behaves as a word.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // True when the low address bits violate the natural alignment of the access size.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      logic m;
      case (size)
         SZ_BYTE: m = 1'b0;
         SZ_HALF: m = a[0];
         SZ_WORD: m = (a != 2'b00);
         default: m = (a != 2'b00);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
// Latency: purely combinational.
// Backpressure: none; outputs follow the inputs.
// Ports: size_i/unsigned_i/lo_i describe the access, wdata_i is right-aligned store data,
//        rdata_i is the raw memory word; be_o/wdata_o drive the bus, rdata_o is the extended load value.
module mem_align (
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);
   import mem_pkg::*;

   logic [31:0] shifted;

   always_comb begin
      // Bring the addressed lane down to bit 0 before picking the width.
      shifted = rdata_i >> {lo_i, 3'b000};
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = shifted;
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = unsigned_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            be_o    = 4'b0011 << lo_i;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = unsigned_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: begin
            // Word and reserved size: full-width pass-through, defaults already hold.
         end
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store controller: turns EX/MEM requests into a req/ack memory transaction.
// Latency: zero-wait memory stalls the pipeline 2 cycles; each memory wait cycle adds one.
// Backpressure: Stall_o holds the upstream pipeline until DONE; WB_o squashed while stalled or faulted.
// Ports: EX/MEM side (MemRead_i, MemWrite_i, Size_i, Unsigned_i, Addr_i, WData_i, WB_i),
//        MEM_WB side (WB_o, Data_o), pipeline control (Stall_o, Misalign_o, BusErr_o),
//        data memory (dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_ack_i, dmem_rdata_i).
module mem_access #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [1:0]  Size_i,
   input  logic        Unsigned_i,
   input  logic [31:0] Addr_i,
   input  logic [31:0] WData_i,
   input  logic [1:0]  WB_i,
   output logic [1:0]  WB_o,
   output logic [31:0] Data_o,
   output logic        Stall_o,
   output logic        Misalign_o,
   output logic        BusErr_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i
);
   import mem_pkg::*;

   localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);
   localparam logic       TIMEOUT_EN  = (ACK_TIMEOUT != 0);

   state_e      state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] data_q, data_d;
   logic        buserr_q, buserr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  cnt_inc;

   logic        access;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;

   assign access = MemRead_i | MemWrite_i;

   // EX/MEM is frozen while stalled, so the live inputs still describe the access
   // when the ack arrives and can drive the load extraction directly.
   mem_align u_align (
      .size_i     (Size_i),
      .unsigned_i (Unsigned_i),
      .lo_i       (Addr_i[1:0]),
      .wdata_i    (WData_i),
      .rdata_i    (dmem_rdata_i),
      .be_o       (al_be),
      .wdata_o    (al_wdata),
      .rdata_o    (al_rdata)
   );

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      data_d     = data_q;
      buserr_d   = 1'b0;
      cnt_d      = cnt_q;
      cnt_inc    = cnt_q + 8'd1;
      Stall_o    = 1'b0;
      WB_o       = WB_i;
      Misalign_o = 1'b0;

      case (state_q)
         IDLE: begin
            if (access) begin
               WB_o = 2'b00;
               if (misaligned(Size_i, Addr_i[1:0])) begin
                  // Faulting access: let the pipeline move on with write-back killed.
                  Misalign_o = 1'b1;
               end else begin
                  Stall_o = 1'b1;
                  req_d   = 1'b1;
                  we_d    = MemWrite_i;  // store wins when both requests are set
                  addr_d  = {Addr_i[31:2], 2'b00};
                  be_d    = al_be;
                  wdata_d = al_wdata;
                  cnt_d   = 8'd0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            Stall_o = 1'b1;
            WB_o    = 2'b00;
            if (dmem_ack_i) begin
               req_d   = 1'b0;
               if (!we_q) begin
                  data_d = al_rdata;
               end
               state_d = DONE;
            end else if (TIMEOUT_EN && (cnt_inc == TIMEOUT_CNT)) begin
               req_d    = 1'b0;
               buserr_d = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE: begin
            // BusErr is high exactly in the DONE cycle of an aborted access,
            // so it doubles as the abort marker for squashing write-back.
            if (buserr_q) begin
               WB_o = 2'b00;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'b0;
         be_q     <= 4'b0;
         wdata_q  <= 32'b0;
         data_q   <= 32'b0;
         buserr_q <= 1'b0;
         cnt_q    <= 8'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         data_q   <= data_d;
         buserr_q <= buserr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign dmem_req_o   = req_q;
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_be_o    = be_q;
   assign dmem_wdata_o = wdata_q;
   assign Data_o       = data_q;
   assign BusErr_o     = buserr_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access with a scoreboard of expected completions.
// Latency: memory model acks after a programmable number of wait cycles.
// Backpressure: stimulus is held until the scoreboard entry for the access has been retired.
module tb_mem_access;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        MemRead_i, MemWrite_i;
   logic [1:0]  Size_i;
   logic        Unsigned_i;
   logic [31:0] Addr_i, WData_i;
   logic [1:0]  WB_i;
   logic [1:0]  WB_o;
   logic [31:0] Data_o;
   logic        Stall_o, Misalign_o, BusErr_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;

   always #5 clk_i = ~clk_i;

   mem_access #(.ACK_TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .Size_i(Size_i), .Unsigned_i(Unsigned_i),
      .Addr_i(Addr_i), .WData_i(WData_i), .WB_i(WB_i),
      .WB_o(WB_o), .Data_o(Data_o), .Stall_o(Stall_o), .Misalign_o(Misalign_o), .BusErr_o(BusErr_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] data;
      logic [1:0]  wb;
      logic        buserr;
      int          stalls;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_data;

   // Memory model controls
   int          mem_wait;
   logic [31:0] mem_rdata;
   bit          mem_never;
   bit          ack_force;
   logic        mem_ack;
   logic [31:0] mem_rd_q;

   assign dmem_ack_i   = mem_ack | ack_force;
   assign dmem_rdata_i = ack_force ? 32'hFFFF_FFFF : mem_rd_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      case (sz)
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] lo);
      logic [3:0] r;
      int n = nbytes(sz);
      int l = int'(lo);
      for (int b = 0; b < 4; b++) r[b] = (b >= l) && (b < l + n);
      return r;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      int n = nbytes(sz);
      for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                            input logic [1:0] lo, input logic [31:0] rd);
      logic [31:0] s, mask;
      int n = nbytes(sz);
      s    = rd >> (8 * int'(lo));
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
      s    = s & mask;
      if (!uns && s[8*n-1]) s = s | ~mask;
      return s;
   endfunction

   // Memory: drives ack/rdata 1 ns after the clock edge.
   initial begin : memory
      int wcnt;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_rd_q = 32'b0;
      forever begin
         @(posedge clk_i);
         #1;
         mem_ack = 1'b0;
         if (dmem_req_o && !mem_never) begin
            if (wcnt == mem_wait) begin
               mem_ack  = 1'b1;
               mem_rd_q = mem_rdata;
               wcnt     = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Monitor: samples on the falling edge; a falling Stall_o marks the DONE cycle.
   initial begin : monitor
      exp_t e;
      int   stall_cnt;
      bit   prev_stall;
      stall_cnt  = 0;
      prev_stall = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_n_i) begin
            stall_cnt  = 0;
            prev_stall = 0;
         end else begin
            if (Stall_o === 1'b1) begin
               stall_cnt++;
               check("wb_squash_stall", {30'b0, WB_o}, 32'd0);
               check("misalign_stall", {31'b0, Misalign_o}, 32'd0);
            end else if (prev_stall) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("stall_cycles", stall_cnt, e.stalls);
                  check("req_dropped", {31'b0, dmem_req_o}, 32'd0);
                  check("we", {31'b0, dmem_we_o}, {31'b0, e.we});
                  check("addr", dmem_addr_o, e.addr);
                  check("be", {28'b0, dmem_be_o}, {28'b0, e.be});
                  check("wdata", dmem_wdata_o, e.wdata);
                  check("data", Data_o, e.data);
                  check("wb_done", {30'b0, WB_o}, {30'b0, e.wb});
                  check("buserr", {31'b0, BusErr_o}, {31'b0, e.buserr});
               end
               stall_cnt = 0;
            end
            prev_stall = (Stall_o === 1'b1);
         end
      end
   end

   task automatic idle_inputs();
      MemRead_i  = 1'b0;
      MemWrite_i = 1'b0;
      Size_i     = 2'b10;
      Unsigned_i = 1'b0;
      Addr_i     = 32'b0;
      WData_i    = 32'b0;
      WB_i       = 2'b11;
   endtask

   // Drives one access (called 2 ns after a rising edge) and waits until its result is retired.
   task automatic run(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] wb,
                      input logic [31:0] rdata, input int waits, input bit never);
      exp_t e;
      e.we    = wr;
      e.addr  = {addr[31:2], 2'b00};
      e.be    = exp_be(sz, addr[1:0]);
      e.wdata = exp_wdata(sz, wd);
      if (!wr && !never) model_data = exp_load(sz, uns, addr[1:0], rdata);
      e.data   = model_data;
      e.wb     = never ? 2'b00 : wb;
      e.buserr = never;
      e.stalls = never ? (1 + 4) : (2 + waits);
      sb_q.push_back(e);
      mem_wait   = waits;
      mem_rdata  = rdata;
      mem_never  = never;
      MemRead_i  = rd;
      MemWrite_i = wr;
      Size_i     = sz;
      Unsigned_i = uns;
      Addr_i     = addr;
      WData_i    = wd;
      WB_i       = wb;
      for (int i = 0; i < 60; i++) begin
         if (sb_q.size() == 0) break;
         @(posedge clk_i);
         #2;
      end
      if (sb_q.size() != 0) begin
         check("sb_drain_timeout", sb_q.size(), 32'd0);
         sb_q.delete();
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic [1:0]  sz;
      logic [31:0] a;
      logic        w;
      idle_inputs();
      rst_n_i    = 1'b0;
      model_data = 32'b0;
      mem_wait   = 0;
      mem_rdata  = 32'b0;
      mem_never  = 1'b0;
      ack_force  = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_req", {31'b0, dmem_req_o}, 32'd0);
      check("rst_we", {31'b0, dmem_we_o}, 32'd0);
      check("rst_addr", dmem_addr_o, 32'd0);
      check("rst_be", {28'b0, dmem_be_o}, 32'd0);
      check("rst_wdata", dmem_wdata_o, 32'd0);
      check("rst_data", Data_o, 32'd0);
      check("rst_buserr", {31'b0, BusErr_o}, 32'd0);
      @(posedge clk_i);
      #2;
      rst_n_i = 1'b1;
      @(negedge clk_i);
      check("idle_stall", {31'b0, Stall_o}, 32'd0);
      check("idle_wb_pass", {30'b0, WB_o}, 32'd3);
      @(posedge clk_i);
      #2;

      // Directed accesses (several back-to-back)
      run(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0, 2'b10, 32'hDEAD_BEEF, 0, 0);  // LW
      run(1, 0, 2'b00, 0, 32'h0000_0013, 32'h0, 2'b10, 32'h8011_2233, 0, 0);  // LB
      run(1, 0, 2'b00, 1, 32'h0000_0013, 32'h0, 2'b10, 32'h8011_2233, 0, 0);  // LBU
      run(0, 1, 2'b01, 0, 32'h0000_0006, 32'h0000_A5A5, 2'b01, 32'h0, 0, 0);  // SH
      run(1, 0, 2'b01, 0, 32'h0000_0022, 32'h0, 2'b10, 32'h8001_1234, 2, 0);  // LH, 2 waits
      run(1, 0, 2'b01, 1, 32'h0000_0022, 32'h0, 2'b10, 32'h8001_1234, 1, 0);  // LHU
      run(0, 1, 2'b00, 0, 32'h0000_0001, 32'h1234_5678, 2'b00, 32'h0, 0, 0);  // SB
      run(0, 1, 2'b10, 0, 32'h0000_0020, 32'hCAFE_F00D, 2'b00, 32'h0, 3, 0);  // SW, 3 waits
      run(1, 1, 2'b10, 0, 32'h0000_0030, 32'h0BAD_CAFE, 2'b10, 32'h5555_AAAA, 0, 0); // both -> store
      run(1, 0, 2'b11, 0, 32'h0000_0040, 32'h0, 2'b10, 32'h1122_3344, 0, 0);  // reserved size as word

      // Misaligned accesses: combinational fault, no request, no stall
      idle_inputs();
      @(posedge clk_i);
      #2;
      MemRead_i = 1'b1; Size_i = 2'b10; Addr_i = 32'h0000_0002; WB_i = 2'b10;
      #1;
      check("mis_lw_flag", {31'b0, Misalign_o}, 32'd1);
      check("mis_lw_stall", {31'b0, Stall_o}, 32'd0);
      check("mis_lw_wb", {30'b0, WB_o}, 32'd0);
      repeat (3) begin
         @(negedge clk_i);
         check("mis_lw_noreq", {31'b0, dmem_req_o}, 32'd0);
      end
      @(posedge clk_i);
      #2;
      Size_i = 2'b01; Addr_i = 32'h0000_0001;
      #1;
      check("mis_lh_flag", {31'b0, Misalign_o}, 32'd1);
      @(negedge clk_i);
      check("mis_lh_noreq", {31'b0, dmem_req_o}, 32'd0);
      idle_inputs();
      @(posedge clk_i);
      #2;

      // Ack never comes: abort after 4 BUSY cycles
      run(1, 0, 2'b10, 0, 32'h0000_0050, 32'h0, 2'b10, 32'h0, 0, 1);
      idle_inputs();
      @(negedge clk_i);
      check("buserr_one_cycle", {31'b0, BusErr_o}, 32'd0);
      check("after_abort_stall", {31'b0, Stall_o}, 32'd0);
      @(posedge clk_i);
      #2;

      // Random aligned accesses with random wait states
      for (int i = 0; i < 16; i++) begin
         sz = 2'($urandom_range(0, 2));
         a  = $urandom_range(0, 32'h0000_FFFF);
         if (sz == 2'd1) a[0] = 1'b0;
         if (sz == 2'd2) a[1:0] = 2'b00;
         w  = 1'($urandom_range(0, 1));
         run(~w, w, sz, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
             $urandom, $urandom_range(0, 3), 0);
      end

      // Reset three cycles into a load, then a late ack must be ignored
      idle_inputs();
      @(posedge clk_i);
      #2;
      mem_never = 1'b1;
      MemRead_i = 1'b1; Size_i = 2'b10; Addr_i = 32'h0000_0070; WB_i = 2'b10;
      repeat (3) begin
         @(posedge clk_i);
         #2;
      end
      check("busy_req_before_rst", {31'b0, dmem_req_o}, 32'd1);
      rst_n_i   = 1'b0;
      MemRead_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      check("rst_busy_req", {31'b0, dmem_req_o}, 32'd0);
      check("rst_busy_stall", {31'b0, Stall_o}, 32'd0);
      check("rst_busy_buserr", {31'b0, BusErr_o}, 32'd0);
      model_data = 32'b0;
      @(posedge clk_i);
      #2;
      rst_n_i   = 1'b1;
      ack_force = 1'b1;
      @(posedge clk_i);
      #2;
      ack_force = 1'b0;
      @(negedge clk_i);
      check("late_ack_req", {31'b0, dmem_req_o}, 32'd0);
      check("late_ack_stall", {31'b0, Stall_o}, 32'd0);
      check("late_ack_data", Data_o, 32'd0);
      check("late_ack_wb", {30'b0, WB_o}, 32'd2);
      @(posedge clk_i);
      #2;

      // Clean recovery from IDLE after the reset
      run(1, 0, 2'b10, 0, 32'h0000_0060, 32'h0, 2'b10, 32'h0BAD_F00D, 0, 0);
      idle_inputs();
      repeat (3) @(posedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register outputs and the MEM_WB pipeline register.
- Converts load and store requests into a req/ack data-memory transaction, with byte-lane steering and load sign/zero extension.
- Stalls the upstream pipeline until the transaction completes.
- Squashes register write-back (WB_o = 0) on every stall cycle and on every fault, so MEM_WB never commits a partial result.

Parameters:
- ACK_TIMEOUT, default 255: maximum number of cycles in BUSY waiting for dmem_ack_i before the access is aborted. 0 disables the timeout. Counter width is 8 bits.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  synchronous active-low reset.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- Size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- Unsigned_i  in  1  zero-extend loads when 1, sign-extend when 0.
- Addr_i  in  32  byte address (ALU result).
- WData_i  in  32  store data, right-aligned.
- WB_i  in  2  {RegWrite, MemtoReg} from EX/MEM.
- WB_o  out  2  WB control to MEM_WB; 00 while stalled or on fault.
- Data_o  out  32  registered, extended load result to MEM_WB.
- Stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- Misalign_o  out  1  combinational fault flag for the current access.
- BusErr_o  out  1  one-cycle pulse on timeout abort.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word-aligned address ({Addr[31:2], 2'b00}).
- dmem_be_o  out  4  byte enables, little-endian.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_ack_i  in  1  completion; valid in the same cycle as dmem_rdata_i.
- dmem_rdata_i  in  32  read word.

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - state goes to IDLE.
  - Registered outputs clear: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, Data_o, BusErr_o and the timeout counter all become 0.
  - This applies mid-transaction too: an outstanding req is dropped and the memory tolerates an abandoned request.
- Access definition: access = MemRead_i | MemWrite_i. If both are set, the access is a store.
- Alignment rules:
  - Half-word accesses require Addr[0] = 0.
  - Word accesses require Addr[1:0] = 00.
  - Byte accesses are always aligned.
- FSM states: IDLE, BUSY, DONE.
- IDLE, aligned access:
  - Stall_o = 1, WB_o = 00.
  - Register req = 1, we, addr, be and wdata; clear the timeout counter; go to BUSY.
- IDLE, misaligned access:
  - Misalign_o = 1, Stall_o = 0, WB_o = 00.
  - No request is issued; remain in IDLE.
- IDLE, no access: Stall_o = 0, WB_o = WB_i, Data_o holds.
- BUSY:
  - Stall_o = 1, WB_o = 00, req held high and all request fields stable.
  - On dmem_ack_i: deassert req. For loads, capture the extracted load data into Data_o; stores leave Data_o unchanged. Go to DONE.
  - On counter reaching ACK_TIMEOUT (when nonzero): deassert req, pulse BusErr_o for 1 cycle, go to DONE with WB squashed.
- DONE:
  - Stall_o = 0; WB_o = WB_i, or 00 if aborted.
  - No new access is started, because EX/MEM still holds the same instruction this cycle.
  - Go to IDLE on the next cycle.
- dmem_ack_i is ignored in IDLE and DONE.
- Byte enables:
  - Byte: 4'b0001 << Addr[1:0].
  - Half: 4'b0011 << Addr[1:0].
  - Word: 4'b1111.
- Store data: byte replicated {4{WData[7:0]}}; half replicated {2{WData[15:0]}}; word passed through.
- Load extraction: shift rdata right by Addr[1:0]*8, take 8/16/32 bits, then sign- or zero-extend to 32 bits.
- Latency: a zero-wait memory (ack in the first BUSY cycle) gives 2 stall cycles. Each extra wait cycle adds 1. MEM_WB captures the result at the DONE→IDLE edge.
- Back-to-back accesses: the second access is detected in IDLE on the cycle after DONE.

Decomposition:
- Package mem_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - The state enum {IDLE, BUSY, DONE}.
  - Function misaligned(size, a[1:0]).
- Sub-module mem_align, combinational: computes be and wdata steering, and load extraction/extension from (size, unsigned, addr[1:0], wdata, rdata).

Test Plan:
1. LW at 0x0000_0010, memory returns 0xDEAD_BEEF with ack in the first BUSY cycle → Stall_o high for 2 cycles; Data_o = 0xDEADBEEF; WB_o = WB_i = 10 only in DONE.
2. LB signed at 0x0000_0013, rdata 0x80112233 → be = 1000; Data_o = 0xFFFFFF80. Same access as LBU → Data_o = 0x00000080.
3. SH of 0x0000_A5A5 at 0x0000_0006 → dmem_we_o = 1, dmem_addr_o = 0x4, be = 1100, wdata = 0xA5A5A5A5; Data_o unchanged.
4. LW at 0x0000_0002 → Misalign_o = 1, no dmem_req_o, Stall_o = 0, WB_o = 00.
5. With ACK_TIMEOUT = 4 and ack never asserted → req drops after 4 BUSY cycles, BusErr_o pulses once, WB_o = 00 in DONE, FSM returns to IDLE.
6. Assert rst_n_i low during BUSY, 3 cycles into a load → next cycle: req = 0, Stall_o = 0, state IDLE; a late ack is ignored.
